// File: rtl/mantissa_pp_pkg.sv
// Shared types and helpers for the mantissa partial-product gating stage.
// Lane geometry: mode m groups 2^m adjacent tiles into one lane.
package mantissa_pp_pkg;

   localparam int MODE_QUARTER = 0;
   localparam int MODE_HALF    = 1;
   localparam int MODE_FULL    = 2;

   // Widest tile count the lane-mask helper can describe.
   localparam int MAX_TILES = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // A tile survives when its row and column fall in the same 2^mode block.
   function automatic logic tile_keep(input int i, input int j, input int mode,
                                      input int log2_tiles);
      if (mode > log2_tiles) begin
         return 1'b0;
      end
      return (i >> mode) == (j >> mode);
   endfunction

   function automatic logic [MAX_TILES-1:0] lane_mask(input int mode, input int tiles);
      logic [MAX_TILES-1:0] mask;
      mask = '0;
      for (int k = 0; k < MAX_TILES; k++) begin
         if (k < tiles && (k % (1 << mode)) == 0) begin
            mask[k] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/mantissa_pp_gate_comb.sv
// Combinational tile gating, lane-start mask and illegal-mode decode.
// Operates on the raw beat before it is captured by the skid buffer.
module mantissa_pp_gate_comb
   import mantissa_pp_pkg::*;
#(
   parameter int TILES  = 4,
   parameter int TW     = 14,
   parameter int MODE_W = 2
) (
   input  logic [TILES*TILES*TW-1:0] pp,
   input  logic [MODE_W-1:0]         mode,
   output logic [TILES*TILES*TW-1:0] gated_pp,
   output logic [TILES-1:0]          lanes,
   output logic                      illegal
);

   localparam int LOG2_TILES = $clog2(TILES);

   // NOTE: every output gets a default at the top of the block, so no path
   // through the loops or branches can leave a latch behind.
   always_comb begin
      gated_pp = '0;
      lanes    = '0;
      illegal  = int'(mode) > LOG2_TILES;

      for (int i = 0; i < TILES; i++) begin
         for (int j = 0; j < TILES; j++) begin
            if (tile_keep(i, j, int'(mode), LOG2_TILES)) begin
               gated_pp[(i*TILES+j)*TW +: TW] = pp[(i*TILES+j)*TW +: TW];
            end
         end
      end

      if (!illegal) begin
         lanes = TILES'(lane_mask(int'(mode), TILES));
      end
   end

endmodule

// File: rtl/mantissa_pp_gate_pipe.sv
// Pipelined partial-product gating stage: gates at the input, then holds
// beats in a 2-entry skid buffer with a registered in_ready.
module mantissa_pp_gate_pipe
   import mantissa_pp_pkg::*;
#(
   parameter int TILES  = 4,
   parameter int TW     = 14,
   parameter int MODE_W = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [TILES*TILES*TW-1:0] in_pp,
   input  logic [MODE_W-1:0]         in_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [TILES*TILES*TW-1:0] out_pp,
   output logic [TILES-1:0]          out_lane_mask,
   output logic [MODE_W-1:0]         out_mode,
   output logic                      err_mode,
   input  logic                      err_clr
);

   localparam int PPW = TILES * TILES * TW;

   typedef struct packed {
      logic [PPW-1:0]    pp;
      logic [TILES-1:0]  lanes;
      logic [MODE_W-1:0] mode;
   } beat_t;

   logic [PPW-1:0]   gated_pp;
   logic [TILES-1:0] gated_lanes;
   logic             gated_illegal;

   mantissa_pp_gate_comb #(
      .TILES  (TILES),
      .TW     (TW),
      .MODE_W (MODE_W)
   ) u_gate (
      .pp       (in_pp),
      .mode     (in_mode),
      .gated_pp (gated_pp),
      .lanes    (gated_lanes),
      .illegal  (gated_illegal)
   );

   skid_state_e state, state_next;
   beat_t       head, skid, incoming;
   logic        accept, deliver;

   assign incoming = {gated_pp, gated_lanes, in_mode};
   assign accept   = in_valid & in_ready;
   assign deliver  = out_valid & out_ready;

   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) state_next = ST_ONE;
         end
         ST_ONE: begin
            out_valid = 1'b1;
            if (accept && !deliver) begin
               state_next = ST_TWO;
            end else if (deliver && !accept) begin
               state_next = ST_EMPTY;
            end
         end
         ST_TWO: begin
            out_valid = 1'b1;
            if (deliver) state_next = ST_ONE;
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b0;
         head     <= '0;
         err_mode <= 1'b0;
      end else begin
         state    <= state_next;
         // Registered from the next state, so never a combinational path from out_ready.
         in_ready <= (state_next != ST_TWO);

         case (state)
            ST_EMPTY: if (accept) head <= incoming;
            ST_ONE:   if (accept && deliver) head <= incoming;
            ST_TWO:   if (deliver) head <= skid;
            default:  head <= head;
         endcase

         if (accept && gated_illegal) begin
            err_mode <= 1'b1;
         end else if (err_clr) begin
            err_mode <= 1'b0;
         end
      end
   end

   // NOTE: the second entry is plain storage and is deliberately not reset;
   // the FSM state alone decides whether its contents are meaningful.
   always_ff @(posedge clk) begin
      if (state == ST_ONE && accept && !deliver) begin
         skid <= incoming;
      end
   end

   assign out_pp        = head.pp;
   assign out_lane_mask = head.lanes;
   assign out_mode      = head.mode;

endmodule
